// File: rtl/analog_scan_sequencer.sv
// Analog front-end scan controller: steps the input muxes, reads one serial ADC frame per
// trigger and routes the tagged sample to the FIFO, the power-monitor register, or drops it.
module analog_scan_sequencer #(
  parameter int DATA_WIDTH     = 12,
  parameter int FRAME_BITS     = 16,
  parameter int MUX_COUNT      = 3,
  parameter int MUX_ADDR_WIDTH = 3,
  parameter int CH_WIDTH       = 5,
  parameter int SCLK_DIV       = 4,
  parameter int SLAVE_DELAY    = 10,
  parameter int SETTLE_CYCLES  = 16,
  parameter logic [MUX_COUNT*(2**MUX_ADDR_WIDTH)-1:0] SKIP_MASK = 24'h000001,
  parameter int POWER_CHANNEL  = 0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                trigger,
  input  logic                                enable,
  output logic [MUX_COUNT*MUX_ADDR_WIDTH-1:0] mux_addr,
  output logic [MUX_COUNT-1:0]                mux_en,
  output logic                                adc_ncs,
  output logic                                adc_sclk,
  input  logic                                adc_sdata,
  input  logic                                fifo_full,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic [CH_WIDTH-1:0]                 out_channel,
  output logic                                out_valid,
  output logic [DATA_WIDTH-1:0]               power_data,
  output logic                                power_valid,
  output logic                                scan_done,
  output logic                                trigger_missed,
  output logic [7:0]                          overflow_count
);
  localparam int TOTAL   = MUX_COUNT * (2**MUX_ADDR_WIDTH);
  localparam int CH_SPAN = 2**CH_WIDTH;
  localparam logic [CH_SPAN-1:0] SKIP_EXT = CH_SPAN'(SKIP_MASK);
  localparam int CNT_MAX = (SLAVE_DELAY > SETTLE_CYCLES) ? SLAVE_DELAY : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PH_W    = $clog2(2 * SCLK_DIV + 1);
  localparam int BIT_W   = $clog2(FRAME_BITS + 1);

  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, DONE, QUIET} state_t;

  state_t                state, state_next;
  logic                  trig_s1, trig_s2, trig_s3, start;
  logic [CNT_W-1:0]      cnt;
  logic [PH_W-1:0]       ph;
  logic [BIT_W-1:0]      bitn;
  logic [DATA_WIDTH-1:0] sreg;
  logic [CH_WIDTH-1:0]   ch;
  logic                  last_phase, last_bit, sample_edge;
  logic                  is_power, is_last, to_fifo;

  // Two synchroniser flops, one history flop, and a registered edge: start is 3 cycles after the edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig_s1 <= 1'b0;
      trig_s2 <= 1'b0;
      trig_s3 <= 1'b0;
      start   <= 1'b0;
    end else begin
      trig_s1 <= trigger;
      trig_s2 <= trig_s1;
      trig_s3 <= trig_s2;
      start   <= trig_s2 & ~trig_s3;
    end
  end

  assign last_phase  = (ph == PH_W'(2 * SCLK_DIV - 1));
  assign last_bit    = (bitn == BIT_W'(FRAME_BITS - 1));
  assign sample_edge = (state == SHIFT) && (ph == PH_W'(SCLK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start && enable) state_next = CS_SETUP;
      CS_SETUP: if (cnt == CNT_W'(SLAVE_DELAY - 1)) state_next = SHIFT;
      SHIFT:    if (last_phase && last_bit) state_next = DONE;
      DONE:     state_next = QUIET;
      QUIET:    if (cnt == CNT_W'(SETTLE_CYCLES - 1)) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // SCLK low for the first half of each bit period; idle level is high
  always_comb begin
    adc_ncs  = 1'b1;
    adc_sclk = 1'b1;
    if (state == CS_SETUP || state == SHIFT) adc_ncs = 1'b0;
    if (state == SHIFT && ph < PH_W'(SCLK_DIV)) adc_sclk = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      ph   <= '0;
      bitn <= '0;
    end else begin
      if (state_next != state)                  cnt <= '0;
      else if (state == CS_SETUP || state == QUIET) cnt <= cnt + 1'b1;
      if (state == SHIFT) begin
        ph <= last_phase ? '0 : ph + 1'b1;
        if (last_phase) bitn <= bitn + 1'b1;
      end else begin
        ph   <= '0;
        bitn <= '0;
      end
    end
  end

  // Keeps only the last DATA_WIDTH bits of the frame; leading bits fall off the top
  always_ff @(posedge clk) begin
    if (sample_edge) sreg <= {sreg[DATA_WIDTH-2:0], adc_sdata};
  end

  assign is_power = (ch == CH_WIDTH'(POWER_CHANNEL));
  assign is_last  = (ch == CH_WIDTH'(TOTAL - 1));
  assign to_fifo  = !SKIP_EXT[ch];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch             <= '0;
      out_data       <= '0;
      out_channel    <= '0;
      out_valid      <= 1'b0;
      power_data     <= '0;
      power_valid    <= 1'b0;
      scan_done      <= 1'b0;
      trigger_missed <= 1'b0;
      overflow_count <= '0;
    end else begin
      out_valid      <= 1'b0;
      power_valid    <= 1'b0;
      scan_done      <= 1'b0;
      trigger_missed <= start && (state != IDLE);
      if (state == DONE) begin
        ch        <= is_last ? '0 : ch + 1'b1;
        scan_done <= is_last;
        if (is_power) begin
          power_data  <= sreg;
          power_valid <= 1'b1;
        end
        if (to_fifo && !fifo_full) begin
          out_valid   <= 1'b1;
          out_data    <= sreg;
          out_channel <= ch;
        end
        if (to_fifo && fifo_full && overflow_count != 8'hFF)
          overflow_count <= overflow_count + 1'b1;
      end
    end
  end

  assign mux_en   = MUX_COUNT'(1) << (ch >> MUX_ADDR_WIDTH);
  assign mux_addr = {MUX_COUNT{ch[MUX_ADDR_WIDTH-1:0]}};

endmodule

// File: tb/tb_analog_scan_sequencer.sv
// Bench for analog_scan_sequencer: serial ADC model, expected-result queues popped on the
// DUT's output strobes, a vector table for the first channels and hand-written corner sequences.
module tb_analog_scan_sequencer;
  localparam int DW = 12, CW = 5, MC = 3, MAW = 3, TOTAL = 24;
  localparam logic [TOTAL-1:0] MASK = 24'h000001;

  logic clk = 1'b0, reset = 1'b1, trigger = 1'b0, enable = 1'b1;
  logic adc_sdata = 1'b0, fifo_full = 1'b0;
  logic [MC*MAW-1:0] mux_addr;
  logic [MC-1:0]     mux_en;
  logic              adc_ncs, adc_sclk, out_valid, power_valid, scan_done, trigger_missed;
  logic [DW-1:0]     out_data, power_data;
  logic [CW-1:0]     out_channel;
  logic [7:0]        overflow_count;

  always #5 clk = ~clk;

  analog_scan_sequencer dut (
    .clk(clk), .reset(reset), .trigger(trigger), .enable(enable),
    .mux_addr(mux_addr), .mux_en(mux_en), .adc_ncs(adc_ncs), .adc_sclk(adc_sclk),
    .adc_sdata(adc_sdata), .fifo_full(fifo_full), .out_data(out_data),
    .out_channel(out_channel), .out_valid(out_valid), .power_data(power_data),
    .power_valid(power_valid), .scan_done(scan_done), .trigger_missed(trigger_missed),
    .overflow_count(overflow_count)
  );

  typedef struct packed {logic [DW-1:0] data; logic [CW-1:0] ch;} exp_t;
  typedef struct {logic [15:0] word; logic full; logic exp_valid; logic [DW-1:0] exp_data; logic [CW-1:0] exp_ch;} vec_t;

  exp_t          out_q[$];
  logic [DW-1:0] pwr_q[$];
  int            scan_q[$];
  vec_t          tbl[6];
  int total = 0, bad = 0, valid_cnt = 0, miss_cnt = 0, ch_m = 0, ovf_m = 0;
  int k, vc0, m0;
  logic [15:0] adc_word = 16'h0;
  int idx = 0;

  // ADC presents the next bit (MSB first) on each SCLK fall; chip-select high rewinds the frame
  always @(negedge adc_sclk or posedge adc_ncs) begin
    if (adc_ncs) idx = 0;
    else if (idx < 16) begin
      adc_sdata = adc_word[15-idx];
      idx++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    logic [DW-1:0] p;
    int s;
    @(posedge clk);
    #1;
    if (trigger_missed) miss_cnt++;
    if (out_valid) begin
      valid_cnt++;
      check("out_valid_expected", 32'(out_q.size() != 0), 1);
      if (out_q.size() != 0) begin
        e = out_q.pop_front();
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_channel", 32'(out_channel), 32'(e.ch));
      end
    end
    if (power_valid) begin
      check("power_valid_expected", 32'(pwr_q.size() != 0), 1);
      if (pwr_q.size() != 0) begin
        p = pwr_q.pop_front();
        check("power_data", 32'(power_data), 32'(p));
      end
    end
    if (scan_done) begin
      check("scan_done_expected", 32'(scan_q.size() != 0), 1);
      if (scan_q.size() != 0) begin
        s = scan_q.pop_front();
        check("scan_done_with_out_valid", 32'(out_valid), s);
      end
    end
  endtask

  task automatic expect_conv(input logic [15:0] word, input logic full);
    exp_t e;
    if (ch_m == 0) pwr_q.push_back(word[DW-1:0]);
    if (!MASK[ch_m]) begin
      if (!full) begin
        e.data = word[DW-1:0];
        e.ch   = CW'(ch_m);
        out_q.push_back(e);
      end else if (ovf_m < 255) ovf_m++;
    end
    if (ch_m == TOTAL - 1) scan_q.push_back(int'(!MASK[ch_m] && !full));
    ch_m = (ch_m + 1) % TOTAL;
  endtask

  task automatic conv(input logic [15:0] word, input logic full, input int period);
    adc_word  = word;
    fifo_full = full;
    trigger   = 1'b1;
    repeat (4) tick();
    trigger = 1'b0;
    repeat (period - 4) tick();
  endtask

  initial begin
    tbl[0] = '{16'h1234, 1'b0, 1'b1, 12'h234, 5'd1};
    tbl[1] = '{16'hFFFF, 1'b0, 1'b1, 12'hFFF, 5'd2};
    tbl[2] = '{16'h0000, 1'b0, 1'b1, 12'h000, 5'd3};
    tbl[3] = '{16'hA5A5, 1'b1, 1'b0, 12'h000, 5'd4};
    tbl[4] = '{16'h5A5A, 1'b0, 1'b1, 12'hA5A, 5'd5};
    tbl[5] = '{16'hF800, 1'b0, 1'b1, 12'h800, 5'd6};

    repeat (3) tick();
    check("rst_mux_en", 32'(mux_en), 1);
    check("rst_mux_addr", 32'(mux_addr), 0);
    check("rst_adc_ncs", 32'(adc_ncs), 1);
    check("rst_adc_sclk", 32'(adc_sclk), 1);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_power_data", 32'(power_data), 0);
    check("rst_overflow", 32'(overflow_count), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    reset = 1'b0;
    repeat (3) tick();

    // First conversion on ch0: latency from trigger edge and the masked-channel routing
    expect_conv(16'h0ABC, 1'b0);
    adc_word = 16'h0ABC;
    trigger  = 1'b1;
    repeat (3) tick();
    check("ncs_before_start", 32'(adc_ncs), 1);
    tick();
    check("ncs_low_after_start", 32'(adc_ncs), 0);
    trigger = 1'b0;
    k = 4;
    while (!power_valid && k < 400) begin
      tick();
      k++;
    end
    check("power_latency", k, 143);
    check("power_data_ch0", 32'(power_data), 32'hABC);
    check("mux_en_after_ch0", 32'(mux_en), 32'b001);
    check("mux_addr_after_ch0", 32'(mux_addr), 32'o111);
    repeat (60) tick();

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].exp_valid) out_q.push_back('{data: tbl[i].exp_data, ch: tbl[i].exp_ch});
      else ovf_m++;
      ch_m++;
      conv(tbl[i].word, tbl[i].full, 200);
    end
    check("overflow_after_table", 32'(overflow_count), 1);

    check("mux_en_ch7", 32'(mux_en), 32'b001);
    check("mux_addr_ch7", 32'(mux_addr), 32'o777);
    expect_conv(16'h0107, 1'b0);
    conv(16'h0107, 1'b0, 200);
    check("mux_en_ch8", 32'(mux_en), 32'b010);
    check("mux_addr_ch8", 32'(mux_addr), 0);

    for (int c = 8; c < TOTAL; c++) begin
      expect_conv(16'h0100 + 16'(c), 1'b0);
      conv(16'h0100 + 16'(c), 1'b0, 200);
    end
    vc0 = valid_cnt;
    for (int c = 0; c < TOTAL; c++) begin
      expect_conv(16'h0100 + 16'(c), 1'b0);
      conv(16'h0100 + 16'(c), 1'b0, 200);
    end
    check("scan_valid_count", valid_cnt - vc0, 23);
    check("wrap_mux_en", 32'(mux_en), 32'b001);
    check("wrap_mux_addr", 32'(mux_addr), 0);

    // Disabled: trigger is ignored entirely
    enable = 1'b0;
    conv(16'h0FFF, 1'b0, 200);
    check("disabled_channel_kept", 32'(mux_addr), 0);
    check("disabled_no_miss", miss_cnt, 0);
    enable = 1'b1;

    expect_conv(16'h0321, 1'b0);
    conv(16'h0321, 1'b0, 200);

    // Second trigger 100 cycles into a conversion is reported and dropped
    expect_conv(16'h0456, 1'b0);
    vc0 = valid_cnt;
    m0  = miss_cnt;
    adc_word = 16'h0456;
    trigger  = 1'b1;
    repeat (4) tick();
    trigger = 1'b0;
    repeat (96) tick();
    trigger = 1'b1;
    repeat (4) tick();
    trigger = 1'b0;
    repeat (200) tick();
    check("missed_pulse_count", miss_cnt - m0, 1);
    check("missed_one_out_valid", valid_cnt - vc0, 1);
    check("missed_channel_step", 32'(mux_addr), 32'o222);

    vc0 = valid_cnt;
    for (int i = 0; i < 300; i++) begin
      expect_conv(16'h0800 + 16'(i), 1'b1);
      conv(16'h0800 + 16'(i), 1'b1, 165);
    end
    fifo_full = 1'b0;
    check("full_no_out_valid", valid_cnt - vc0, 0);
    check("overflow_saturated", 32'(overflow_count), 255);
    check("overflow_model", 32'(overflow_count), ovf_m);

    // Reset 50 cycles into SHIFT aborts the conversion with no output
    adc_word = 16'h0777;
    trigger  = 1'b1;
    repeat (4) tick();
    trigger = 1'b0;
    repeat (60) tick();
    check("ncs_low_in_shift", 32'(adc_ncs), 0);
    reset = 1'b1;
    #1;
    check("ncs_on_reset", 32'(adc_ncs), 1);
    check("sclk_on_reset", 32'(adc_sclk), 1);
    repeat (3) tick();
    reset = 1'b0;
    ch_m  = 0;
    ovf_m = 0;
    check("reset_overflow_clear", 32'(overflow_count), 0);
    check("reset_mux_en", 32'(mux_en), 1);
    check("reset_mux_addr", 32'(mux_addr), 0);
    repeat (200) tick();
    expect_conv(16'h0AAA, 1'b0);
    conv(16'h0AAA, 1'b0, 200);
    expect_conv(16'h0BBB, 1'b0);
    conv(16'h0BBB, 1'b0, 200);

    check("out_queue_drained", out_q.size(), 0);
    check("power_queue_drained", pwr_q.size(), 0);
    check("scan_queue_drained", scan_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/analog_scan_sequencer.md
# analog_scan_sequencer

Parametrised analog front-end controller that merges multiplexer switching, serial ADC readout and per-channel distribution into one block. On each sample trigger it reads one conversion from a serial ADC, tags it with the current multiplexer channel, and routes it. Samples go to the analog FIFO, to the power-monitor register, or are dropped. The channel then advances to the next input. It sits between the mux/ADC pins and the analog buffer feeding the frame filler, and generalises channel count, mux count, sample width and serial frame length.

## Interface
- DATA_WIDTH, 12, sample width delivered downstream
- FRAME_BITS, 16, SCLK periods per conversion; sample = last DATA_WIDTH bits received; FRAME_BITS ≥ DATA_WIDTH
- MUX_COUNT, 3, number of analog multiplexers
- MUX_ADDR_WIDTH, 3, address lines per mux; channels per mux = 2^MUX_ADDR_WIDTH
- CH_WIDTH, 5, channel index width; 2^CH_WIDTH ≥ TOTAL = MUX_COUNT·2^MUX_ADDR_WIDTH (24 by default)
- SCLK_DIV, 4, clk cycles per SCLK half-period (≥1)
- SLAVE_DELAY, 10, clk cycles from adc_ncs falling to first SCLK falling edge
- SETTLE_CYCLES, 16, quiet cycles after each conversion (mux settling, ADC quiet time)
- SKIP_MASK, 24'h000001, bit c = 1 means channel c is never written to the FIFO
- POWER_CHANNEL, 0, channel whose sample updates power_data

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- trigger  in  1  sample request; asynchronous to clk; rising edge starts a conversion
- enable  in  1  1 = accept triggers
- mux_addr  out  MUX_COUNT·MUX_ADDR_WIDTH  identical sub-address replicated to every mux, mux 0 in LSBs
- mux_en  out  MUX_COUNT  one-hot enable of the mux holding the current channel
- adc_ncs  out  1  ADC chip select, active-low
- adc_sclk  out  1  ADC serial clock, idles high
- adc_sdata  in  1  ADC serial data, MSB first
- fifo_full  in  1  analog FIFO full
- out_data  out  DATA_WIDTH  sample to FIFO
- out_channel  out  CH_WIDTH  channel of out_data
- out_valid  out  1  one-cycle FIFO write strobe
- power_data  out  DATA_WIDTH  last POWER_CHANNEL sample
- power_valid  out  1  one-cycle pulse when power_data updates
- scan_done  out  1  one-cycle pulse when channel TOTAL−1 completes
- trigger_missed  out  1  one-cycle pulse when a trigger edge arrives while busy
- overflow_count  out  8  samples dropped on fifo_full; saturates at 255

## Operation
- trigger passes a 2-flop synchroniser and a rising-edge detector. An edge is a one-cycle internal start.
- Current channel c decodes as: mux index m = c >> MUX_ADDR_WIDTH; sub-address = c[MUX_ADDR_WIDTH−1:0]. mux_en = 1<<m. mux_addr carries the sub-address in every field.
- FSM:
  - IDLE: on start with enable=1, go to CS_SETUP. On start with enable=0, ignore it and emit no pulse.
  - CS_SETUP: adc_ncs=0 for SLAVE_DELAY cycles, then go to SHIFT.
  - SHIFT: FRAME_BITS SCLK periods. SCLK goes low for SCLK_DIV cycles, then high for SCLK_DIV cycles. adc_sdata is sampled into the shift register on the clk edge where SCLK returns high. After the last bit, adc_ncs=1 and adc_sclk=1, then go to DONE.
  - DONE, one cycle:
    - Route the sample.
    - Advance c: TOTAL−1 wraps to 0, otherwise c+1.
    - Update mux_addr/mux_en.
    - Go to QUIET.
  - QUIET: SETTLE_CYCLES cycles with adc_ncs high, then go to IDLE.
- Routing in DONE (the rules are independent and may coincide):
  - c == POWER_CHANNEL: latch power_data and pulse power_valid.
  - SKIP_MASK[c] == 0 and fifo_full == 0: out_valid=1, out_data = sample, out_channel = c.
  - SKIP_MASK[c] == 0 and fifo_full == 1: out_valid stays 0 and overflow_count increments, saturating.
  - c == TOTAL−1: pulse scan_done. This happens even if the channel is masked.
- A start in any state other than IDLE causes a trigger_missed pulse and no other effect.
- If enable falls mid-conversion, the conversion still completes; later triggers are ignored. The channel index is retained.

## Timing
- Reset values:
  - c = 0; mux_en = 1, mux_addr = 0
  - adc_ncs = 1, adc_sclk = 1
  - out_data, out_channel, power_data = 0
  - all pulses = 0; overflow_count = 0
  - FSM = IDLE
- Reset is asynchronous, so mid-conversion it forces adc_ncs/adc_sclk high immediately and aborts the conversion with no output.
- Trigger rising edge to internal start: 3 clk cycles.
- Start to adc_ncs low: 1 cycle.
- adc_ncs low duration: SLAVE_DELAY + 2·SCLK_DIV·FRAME_BITS cycles; defaults give 10+128 = 138.
- Start to out_valid: 1 + 138 + 1 = 140 cycles at defaults.
- Minimum conversion period: 140 + SETTLE_CYCLES = 156 cycles. A start earlier than that is missed.
- mux_addr/mux_en change only in DONE.

## Test plan
- Reset, then trigger with the ADC model returning 16'h0ABC on ch0 → no out_valid; power_data = 12'hABC and power_valid pulses 140 cycles after start; mux_en = 3'b001, mux_addr = 9'o111 (sub-address 1).
- 24 triggers at a 200-cycle period, ch c returning 16'h0100+c → 23 out_valid pulses (ch1..23, data 12'h101..12'h117, out_channel matching); scan_done coincides with ch23; channel wraps to 0 with mux_en = 3'b001.
- Check mux_en / sub-address on ch7 → ch8 transition → mux_en goes 3'b001 → 3'b010 and sub-address 7 → 0 in DONE.
- Second trigger 100 cycles after the first → trigger_missed pulse; exactly one out_valid.
- Hold fifo_full = 1 for 300 conversions on unmasked channels → no out_valid; overflow_count saturates at 255.
- Assert reset 50 cycles into SHIFT → adc_ncs = 1 the same cycle; no out_valid; after release, the next conversion uses ch0.
